cpu_sequencer: RTL

Instruction sequencer for the 16-bit accumulator CPU. It sits directly upstream of the decode stage. It drives the one-hot phase strobes FETCH/EXEC1/EXEC2, captures the instruction word into the opcode (IR) and operand registers, and derives the EQ/MI condition flags that decode uses for conditional jumps. It also provides run/step control, a halt state entered on STP, and a saturating retired-instruction counter for debug.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/instr_counter.sv | 28 ++
 rtl/cpu_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit accumulator CPU.
//   - data/opcode width defaults
//   - sequencer state encoding
//   - opcode constants (upper OPC_W bits of an instruction word)
package cpu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int OPC_W_DEF  = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC1 = 3'd2,
        S_EXEC2 = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JEQ = 4'h5;
    localparam logic [3:0] OP_JMI = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_OR  = 4'h9;
    localparam logic [3:0] OP_XOR = 4'hA;
    localparam logic [3:0] OP_NOT = 4'hB;
    localparam logic [3:0] OP_SHL = 4'hC;
    localparam logic [3:0] OP_SHR = 4'hD;
    localparam logic [3:0] OP_ASR = 4'hE;

endpackage

// File: rtl/instr_counter.sv
// instr_counter: saturating up-counter for retired instructions.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears to 0)
//   inc             count one retirement this cycle
//   load/load_value debug preload; reset has priority, load beats inc
//   count           current value; sticks at all-ones
module instr_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction sequencer upstream of decode.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   run                  level: free-running execution
//   step                 pulse: one instruction, honoured only in IDLE with run=0
//   ram_q                instruction word, valid during FETCH
//   EXTRA                from decode, sampled in EXEC1: instruction needs EXEC2
//   acc                  accumulator, source of EQ/MI
//   FETCH/EXEC1/EXEC2    one-hot phase strobes decoded from the state register
//   IR, operand          instruction fields captured on the FETCH->EXEC1 edge
//   EQ, MI               combinational flags: acc==0, acc sign bit
//   halted               high in HALT (entered on STP, left only by reset)
//   instr_count          saturating retired-instruction count
//   cnt_preload(_value)  debug preload of instr_count; tie low in normal use
//   state_dbg            raw state register for observation
//
// Control: run and step are plain levels/pulses with no handshake. A step
// pulse seen outside IDLE (or together with run) is dropped, never queued;
// clearing run lets the current instruction finish and then parks in IDLE.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OPC_W  = OPC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    step,
    input  logic [DATA_W-1:0]       ram_q,
    input  logic                    EXTRA,
    input  logic [DATA_W-1:0]       acc,
    input  logic                    cnt_preload,
    input  logic [CNT_W-1:0]        cnt_preload_value,
    output logic                    FETCH,
    output logic                    EXEC1,
    output logic                    EXEC2,
    output logic [OPC_W-1:0]        IR,
    output logic [DATA_W-OPC_W-1:0] operand,
    output logic                    EQ,
    output logic                    MI,
    output logic                    halted,
    output logic [CNT_W-1:0]        instr_count,
    output logic [2:0]              state_dbg
);

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_FETCH = S_FETCH;
    localparam logic [2:0] ST_EXEC1 = S_EXEC1;
    localparam logic [2:0] ST_EXEC2 = S_EXEC2;
    localparam logic [2:0] ST_HALT  = S_HALT;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       is_stp;
    logic       retire;

    assign is_stp = (IR == OPC_W'(OP_STP));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = (run || step) ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_nxt = ST_EXEC1;
            ST_EXEC1: begin
                if (is_stp)     state_nxt = ST_HALT;
                else if (EXTRA) state_nxt = ST_EXEC2;
                else            state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_EXEC2: state_nxt = run ? ST_FETCH : ST_IDLE;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            IR      <= '0;
            operand <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH) begin
                IR      <= ram_q[DATA_W-1 -: OPC_W];
                operand <= ram_q[DATA_W-OPC_W-1:0];
            end
        end
    end

    // An instruction retires when it leaves EXEC1 without needing EXEC2
    // (STP counts), or when it leaves EXEC2.
    assign retire = ((state == ST_EXEC1) && (is_stp || !EXTRA)) ||
                    (state == ST_EXEC2);

    instr_counter #(.W(CNT_W)) u_instr_counter (
        .clk        (clk),
        .reset      (reset),
        .inc        (retire),
        .load       (cnt_preload),
        .load_value (cnt_preload_value),
        .count      (instr_count)
    );

    assign FETCH     = (state == ST_FETCH);
    assign EXEC1     = (state == ST_EXEC1);
    assign EXEC2     = (state == ST_EXEC2);
    assign halted    = (state == ST_HALT);
    assign state_dbg = state;

    assign EQ = (acc == '0);
    assign MI = acc[DATA_W-1];

endmodule
